// File: rtl/id_ex_alu_feed.sv
// ============================================================================
//  Module   : id_ex_alu_feed
//  Brief    : ID/EX pipeline register feeding alu_32bit. It performs the ALU
//             control decode, applies operand forwarding and uses a
//             valid/ready handshake with a flush input.
//  Options  : FWD_EN - build the EX/MEM and MEM/WB forwarding muxes
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_alu_feed #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic             ex_ready,
    input  logic             flush,
    input  logic [1:0]       id_aluop,
    input  logic [5:0]       id_funct,
    input  logic [4:0]       id_shamt,
    input  logic             id_alusrc,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic [RADDR-1:0] id_rd,
    input  logic [WIDTH-1:0] id_rs_data,
    input  logic [WIDTH-1:0] id_rt_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_regwrite,
    input  logic             exmem_regwrite,
    input  logic             memwb_regwrite,
    input  logic [RADDR-1:0] exmem_rd,
    input  logic [RADDR-1:0] memwb_rd,
    input  logic [WIDTH-1:0] exmem_result,
    input  logic [WIDTH-1:0] memwb_data,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_first,
    output logic [WIDTH-1:0] alu_second,
    output logic [4:0]       alu_shamt,
    output logic             ex_valid,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_regwrite,
    output logic             ex_illegal
);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_NOR = 4'b1100;
    localparam logic [3:0] c_OP_SLL = 4'b1101;
    localparam logic [3:0] c_OP_SRL = 4'b1110;

    logic             r_valid;
    logic [3:0]       r_op;
    logic             r_illegal;
    logic             r_regwrite;
    logic [RADDR-1:0] r_rd;
    logic [RADDR-1:0] r_rs;
    logic [RADDR-1:0] r_rt;
    logic [WIDTH-1:0] r_rs_data;
    logic [WIDTH-1:0] r_rt_data;
    logic [WIDTH-1:0] r_imm;
    logic             r_alusrc;
    logic [4:0]       r_shamt;

    logic [3:0]       w_dec_op;
    logic             w_dec_illegal;
    logic             w_load;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_rs_fwd;
    logic [WIDTH-1:0] w_rt_fwd;

    // Undecodable combinations fall back to ADD and are flagged illegal.
    always_comb begin
        w_dec_op      = c_OP_ADD;
        w_dec_illegal = 1'b0;
        case (id_aluop)
            2'b00: w_dec_op = c_OP_ADD;
            2'b01: w_dec_op = c_OP_SUB;
            2'b10: begin
                case (id_funct)
                    6'b100000, 6'b100001: w_dec_op = c_OP_ADD;
                    6'b100010, 6'b100011: w_dec_op = c_OP_SUB;
                    6'b100100:            w_dec_op = c_OP_AND;
                    6'b100101:            w_dec_op = c_OP_OR;
                    6'b100111:            w_dec_op = c_OP_NOR;
                    6'b101010:            w_dec_op = c_OP_SLT;
                    6'b000000:            w_dec_op = c_OP_SLL;
                    6'b000010:            w_dec_op = c_OP_SRL;
                    default:              w_dec_illegal = 1'b1;
                endcase
            end
            default: w_dec_illegal = 1'b1;
        endcase
    end

    assign id_ready = ex_ready | ~r_valid;
    assign w_load   = id_valid & id_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_op       <= 4'b0000;
            r_illegal  <= 1'b0;
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_alusrc   <= 1'b0;
            r_shamt    <= 5'd0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_op       <= w_dec_op;
            r_illegal  <= w_dec_illegal;
            r_regwrite <= id_regwrite & ~w_dec_illegal & (id_rd != '0);
            r_rd       <= id_rd;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_rs_data  <= id_rs_data;
            r_rt_data  <= id_rt_data;
            r_imm      <= id_imm;
            r_alusrc   <= id_alusrc;
            r_shamt    <= id_shamt;
        end else if (ex_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef FWD_EN
    // EX/MEM is the younger producer, so it wins over MEM/WB; r0 never forwards.
    always_comb begin
        w_rs_fwd = r_rs_data;
        if (exmem_regwrite && (exmem_rd == r_rs) && (r_rs != '0))
            w_rs_fwd = exmem_result;
        else if (memwb_regwrite && (memwb_rd == r_rs) && (r_rs != '0))
            w_rs_fwd = memwb_data;
    end

    always_comb begin
        w_rt_fwd = r_rt_data;
        if (exmem_regwrite && (exmem_rd == r_rt) && (r_rt != '0))
            w_rt_fwd = exmem_result;
        else if (memwb_regwrite && (memwb_rd == r_rt) && (r_rt != '0))
            w_rt_fwd = memwb_data;
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
                            exmem_result, memwb_data, r_rs, r_rt};
    assign w_rs_fwd = r_rs_data;
    assign w_rt_fwd = r_rt_data;
`endif

    assign w_is_shift = (r_op == c_OP_SLL) | (r_op == c_OP_SRL);

    assign alu_op      = r_op;
    assign alu_first   = w_is_shift ? w_rt_fwd : w_rs_fwd;
    assign alu_second  = w_is_shift ? '0 : (r_alusrc ? r_imm : w_rt_fwd);
    assign alu_shamt   = w_is_shift ? r_shamt : 5'd0;
    assign ex_valid    = r_valid;
    assign ex_rd       = r_rd;
    assign ex_regwrite = r_regwrite;
    assign ex_illegal  = r_illegal;

endmodule

`default_nettype wire

// File: doc/id_ex_alu_feed.md
Name: id_ex_alu_feed

Overview:
- ID/EX pipeline stage directly upstream of alu_32bit.
- Captures decoded instruction fields from ID and performs ALU-control decode (aluop/funct to the 4-bit ALU op).
- Applies EX/MEM and MEM/WB operand forwarding, then drives the ALU inputs op, first, second and shamt.
- Valid/ready handshake toward ID and EX, plus a flush input for branch squash.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  stage can accept an instruction
- ex_ready  in  1  EX/MEM consumes the current instruction this cycle
- flush  in  1  squash the held instruction
- id_aluop  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type, 11 reserved
- id_funct  in  6  R-type funct
- id_shamt  in  5  shift amount
- id_alusrc  in  1  1: second operand = immediate
- id_rs, id_rt, id_rd  in  RADDR  source and destination register numbers
- id_rs_data, id_rt_data  in  WIDTH  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_regwrite  in  1  instruction writes a register
- exmem_regwrite, memwb_regwrite  in  1  later-stage write enables
- exmem_rd, memwb_rd  in  RADDR  later-stage destination registers
- exmem_result, memwb_data  in  WIDTH  later-stage write values
- alu_op  out  4  to ALU op
- alu_first, alu_second  out  WIDTH  to ALU first/second
- alu_shamt  out  5  to ALU shamt
- ex_valid  out  1  held instruction is valid
- ex_rd  out  RADDR  registered destination
- ex_regwrite  out  1  registered write enable (qualified)
- ex_illegal  out  1  held instruction has an undecodable op

Behaviour:
- Reset (async, rst=1): all registers 0. Consequences: ex_valid=0, alu_op=0000, alu_shamt=0, ex_rd=0, ex_regwrite=0, ex_illegal=0.
- id_ready = ex_ready | ~ex_valid. This is combinational and has no dependence on id_valid.
- Load: id_valid & id_ready at a posedge captures all ID fields and sets ex_valid=1.
  - Latency: 1 cycle from ID to ALU inputs.
- Drain: ex_ready & ~(id_valid & id_ready) at a posedge clears ex_valid.
- Hold: ex_valid & ~ex_ready keeps every register unchanged.
- Flush: takes priority over load and hold.
  - At the next posedge ex_valid=0 and ex_regwrite=0.
  - The same-cycle ID instruction is not captured.
- Decode at capture time:
  - aluop 00 gives 0010; aluop 01 gives 0110.
  - aluop 10 with funct:
    - 100000/100001 give 0010.
    - 100010/100011 give 0110.
    - 100100 gives 0000.
    - 100101 gives 0001.
    - 100111 gives 1100.
    - 101010 gives 0111.
    - 000000 (sll) gives 1101.
    - 000010 (srl) gives 1110.
  - Any other combination (including aluop 11): alu_op=0010, ex_illegal=1, ex_regwrite forced 0.
- ex_regwrite = captured id_regwrite & ~illegal & (id_rd != 0).
- Forwarding is combinational on the registered rs/rt and the live later-stage inputs. Per source register r:
  - If exmem_regwrite & exmem_rd==r & r!=0, use exmem_result.
  - Else if memwb_regwrite & memwb_rd==r & r!=0, use memwb_data.
  - Else use the registered file data.
  - EX/MEM has priority over MEM/WB.
- Operand routing:
  - Shifts (alu_op 1101/1110): alu_first = forwarded rt, alu_second = 0, alu_shamt = registered shamt.
  - All other ops: alu_first = forwarded rs; alu_second = immediate if alusrc, else forwarded rt; alu_shamt = 0.
- When ex_valid=0, the ALU outputs still reflect the registered contents. Downstream must qualify with ex_valid.

Optional Feature:
- FWD_EN defined: forwarding muxes exactly as in Behaviour.
- FWD_EN undefined: no forwarding logic is built; operands come only from registered id_rs_data/id_rt_data/id_imm. The forwarding input ports remain but are ignored.

Test Plan:
- Reset mid-operation: hold a valid instruction, assert rst asynchronously between edges. Required: ex_valid=0, alu_op=0000 and ex_regwrite=0 immediately, with no clock edge needed.
- R-type and: aluop=10, funct=100100, rs_data=35, rt_data=16, valid, ex_ready=1. Next cycle: alu_op=0000, first=35, second=16, ex_valid=1.
- sll: funct=000000, rt_data=85, shamt=3. Required: alu_op=1101, first=85, second=0, alu_shamt=3. srl with shamt=8 and rt_data=657 gives alu_op=1110, first=657, alu_shamt=8.
- Forward priority: rs=5, rs_data=1; exmem writes r5 with 97 and memwb writes r5 with 42. Required: first=97. Deassert exmem_regwrite: first=42. Set rs=0 with both writing r0: first=1.
- Stall/flush: ex_ready=0 with ex_valid=1 gives id_ready=0, and the outputs hold for 3 cycles despite new ID data. Assert flush: next cycle ex_valid=0 and the flush-cycle ID instruction is not captured.
- Illegal: aluop=10, funct=111111, id_regwrite=1, rd=8. Required: ex_illegal=1, alu_op=0010, ex_regwrite=0. Also aluop=00 with alusrc=1, rs_data=48, imm=987 gives alu_op=0010, second=987.
